eth_phy_10g_link_ctrl: RTL
==========================

// Module: eth_phy_10g_link_ctrl
// PURPOSE
//  Bring-up and self-test sequencer for the 10G PHY. Pulses PHY reset, waits for block lock,
//  runs a timed PRBS31 error-count window, returns the PHY to normal XGMII mode, then waits
//  for rx_status. Sits beside eth_phy_10g, drives its cfg_*_prbs31_enable, reads its RX status.
// PARAMETERS
//  RST_CYCLES        16      cycles phy_reset_req is held high
//  LOCK_TIMEOUT      65536   max cycles in WAIT_LOCK and in WAIT_STATUS
//  SETTLE_CYCLES     64      cycles after a PRBS enable/disable change during which errors are ignored
//  PRBS_TEST_CYCLES  1024    length of the error-accumulation window
//  ERR_THRESHOLD     0       max err_total that still passes
//  TMR_WIDTH         24      timer width; must hold max(all cycle parameters)
// PORTS
//  rx_clk               in   1   sole clock (PHY RX clock)
//  rx_rst               in   1   synchronous, active-high reset
//  start                in   1   pulse: begin sequence (ignored while busy)
//  abort                in   1   level/pulse: terminate the sequence in progress
//  rx_block_lock        in   1   from PHY
//  rx_status            in   1   from PHY
//  rx_high_ber          in   1   from PHY
//  rx_error_count       in   7   per-cycle PRBS error count from PHY
//  phy_reset_req        out  1   high for RST_CYCLES; drives PHY tx_rst/rx_rst
//  cfg_tx_prbs31_enable out  1   to PHY
//  cfg_rx_prbs31_enable out  1   to PHY (always equal to the TX enable)
//  busy                 out  1   high in every state except IDLE and DONE
//  done                 out  1   high in DONE until the next accepted start
//  pass                 out  1   valid when done
//  fail_code            out  3   0 ok, 1 lock timeout, 2 lock lost in PRBS, 3 errors > threshold,
//                                4 status timeout, 5 aborted
//  err_total            out  16  saturating sum of rx_error_count over the test window
//  link_up              out  1   done & pass & rx_status
// BEHAVIOUR
//  Reset: state IDLE; every output 0; timer 0.
//  All outputs are registered; the state decision is visible at the outputs 1 cycle later.
//  FSM states: IDLE, PHY_RST, WAIT_LOCK, PRBS_SETTLE, PRBS_TEST, NORM_SETTLE, WAIT_STATUS, DONE.
//  - IDLE/DONE + start: clear err_total, fail_code, pass, done -> PHY_RST.
//  - PHY_RST: phy_reset_req=1 for RST_CYCLES cycles -> WAIT_LOCK.
//  - WAIT_LOCK: rx_block_lock -> PRBS_SETTLE with enables=1. Timer reaches LOCK_TIMEOUT -> DONE, code 1.
//  - PRBS_SETTLE: SETTLE_CYCLES cycles; rx_error_count ignored -> PRBS_TEST.
//  - PRBS_TEST: for PRBS_TEST_CYCLES cycles, err_total += rx_error_count, saturating at 16'hFFFF.
//    Lock loss -> DONE, code 2, enables=0. Window end -> NORM_SETTLE, enables=0.
//  - NORM_SETTLE: SETTLE_CYCLES cycles -> WAIT_STATUS.
//  - WAIT_STATUS: rx_status -> DONE; code 3 if err_total > ERR_THRESHOLD, otherwise code 0 and pass=1.
//    Timeout (LOCK_TIMEOUT) -> DONE, code 4.
//  - abort in any busy state -> DONE, code 5; enables and phy_reset_req cleared on the same edge.
//  - abort has priority over every other transition. Timeout has priority over the success
//    condition in the same cycle.
//  - rx_high_ber is not checked separately; it is covered by rx_status.
//  Timer is cleared on every state change; it counts up and never wraps inside a state.
//  Enables are quasi-static. A TX-domain consumer synchronizes cfg_tx_prbs31_enable;
//  SETTLE_CYCLES absorbs that latency.
//  rx_rst asserted mid-sequence returns the block to IDLE and clears all outputs immediately.
// STRUCTURE
//  Header eth_phy_10g_ctrl_defs.vh holds the state encodings and FAIL_* codes; the bench includes it too.
//  One sub-module: eth_phy_10g_ctrl_timer. It has clear, enable and terminal-count compare, and
//  is shared by all timed states.
//  The rest is the FSM, the err_total accumulator and the output registers.
// TESTING
//  Bench runs with reduced parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8,
//  PRBS_TEST_CYCLES=32. Loopback uses the PHY with SCRAMBLER_DISABLE=1.
//  1 Clean loopback, start -> phy_reset_req high for exactly 4 cycles; enables high until the window
//    ends; done=1, pass=1, fail_code=0, err_total=0, link_up=1.
//  2 rx_block_lock tied 0 -> done exactly 100 cycles after WAIT_LOCK entry; fail_code=1; enables never set.
//  3 rx_error_count forced to 3 for the whole window -> err_total=96, fail_code=3, pass=0.
//    The same errors injected only during PRBS_SETTLE -> err_total=0.
//  4 rx_error_count=127 with PRBS_TEST_CYCLES=1024 -> err_total saturates at 16'hFFFF.
//  5 rx_block_lock dropped at window cycle 10 -> fail_code=2, enables 0 next cycle.
//    rx_status held 0 after the window -> fail_code=4.
//  6 abort during PRBS_TEST -> fail_code=5, enables 0.
//    start while busy -> ignored. rx_rst mid-sequence -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/eth_phy_10g_link_ctrl_pkg.sv
// Shared types for the 10G PHY bring-up / PRBS self-test sequencer.
package eth_phy_10g_link_ctrl_pkg;

  localparam int unsigned ERR_W     = 16;
  localparam int unsigned ERR_SUM_W = ERR_W + 1;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned CODE_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PHY_RST     = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_PRBS_SETTLE = 3'd3,
    ST_PRBS_TEST   = 3'd4,
    ST_NORM_SETTLE = 3'd5,
    ST_WAIT_STATUS = 3'd6,
    ST_DONE        = 3'd7
  } state_e;

  typedef enum logic [CODE_W-1:0] {
    FAIL_NONE           = 3'd0,
    FAIL_LOCK_TIMEOUT   = 3'd1,
    FAIL_LOCK_LOST      = 3'd2,
    FAIL_ERRORS         = 3'd3,
    FAIL_STATUS_TIMEOUT = 3'd4,
    FAIL_ABORTED        = 3'd5
  } fail_e;

  typedef struct packed {
    logic             pass;
    fail_e            code;
    logic [ERR_W-1:0] err;
  } result_t;

  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

  // Saturating accumulate of one per-cycle error count.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [ERR_SUM_W-1:0] s;
    s = ERR_SUM_W'(a) + ERR_SUM_W'(b);
    return s[ERR_W] ? '1 : s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/eth_phy_10g_link_ctrl_if.sv
// PHY-facing control/status bundle between the sequencer and eth_phy_10g.
interface eth_phy_10g_link_ctrl_if;
  import eth_phy_10g_link_ctrl_pkg::*;

  logic             phy_reset_req;
  logic             cfg_tx_prbs31_enable;
  logic             cfg_rx_prbs31_enable;
  logic             rx_block_lock;
  logic             rx_status;
  logic             rx_high_ber;
  logic [CNT_W-1:0] rx_error_count;

  modport master (
    output phy_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
    input  rx_block_lock, rx_status, rx_high_ber, rx_error_count
  );

  modport slave (
    input  phy_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
    output rx_block_lock, rx_status, rx_high_ber, rx_error_count
  );
endinterface

// File: rtl/eth_phy_10g_link_ctrl_timer.sv
// Per-state cycle timer: cleared on state change, saturates instead of wrapping.
module eth_phy_10g_link_ctrl_timer #(
  parameter int unsigned TMR_WIDTH = 24
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TMR_WIDTH-1:0] tc_value,
  output logic                 tc_hit_c
);

  logic [TMR_WIDTH-1:0] count;

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TMR_WIDTH'(1);
    end
  end

  assign tc_hit_c = (count == tc_value);

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// Bring-up sequencer: PHY reset, block lock, PRBS31 error window, return to XGMII, rx_status.
module eth_phy_10g_link_ctrl
  import eth_phy_10g_link_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES       = 16,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned SETTLE_CYCLES    = 64,
  parameter int unsigned PRBS_TEST_CYCLES = 1024,
  parameter int unsigned ERR_THRESHOLD    = 0,
  parameter int unsigned TMR_WIDTH        = 24
) (
  input  logic                       rx_clk,
  input  logic                       rx_rst,
  input  logic                       start,
  input  logic                       abort,
  eth_phy_10g_link_ctrl_if.master    phy,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CODE_W-1:0]          fail_code,
  output logic [ERR_W-1:0]           err_total,
  output logic                       link_up
);

  state_e               state_q, state_d;
  result_t              res_q, res_d;
  logic [TMR_WIDTH-1:0] tc_value;
  logic                 tc_hit_c;
  logic                 unused_high_ber;

  // Loss of high-BER is already reflected in rx_status.
  assign unused_high_ber = phy.rx_high_ber;

  // Terminal count for whichever state is timing; timer counts 0..N-1.
  always_comb begin
    tc_value = '1;
    case (state_q)
      ST_PHY_RST:                   tc_value = TMR_WIDTH'(RST_CYCLES - 1);
      ST_WAIT_LOCK, ST_WAIT_STATUS: tc_value = TMR_WIDTH'(LOCK_TIMEOUT - 1);
      ST_PRBS_SETTLE,
      ST_NORM_SETTLE:               tc_value = TMR_WIDTH'(SETTLE_CYCLES - 1);
      ST_PRBS_TEST:                 tc_value = TMR_WIDTH'(PRBS_TEST_CYCLES - 1);
      default:                      tc_value = '1;
    endcase
  end

  eth_phy_10g_link_ctrl_timer #(.TMR_WIDTH(TMR_WIDTH)) u_timer (
    .rx_clk   (rx_clk),
    .rx_rst   (rx_rst),
    .clr      (state_d != state_q),
    .en       (1'b1),
    .tc_value (tc_value),
    .tc_hit_c (tc_hit_c)
  );

  // State register and output registers, all decoded from the next state.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q                  <= ST_IDLE;
      res_q                    <= '0;
      busy                     <= 1'b0;
      done                     <= 1'b0;
      pass                     <= 1'b0;
      fail_code                <= '0;
      err_total                <= '0;
      link_up                  <= 1'b0;
      phy.phy_reset_req        <= 1'b0;
      phy.cfg_tx_prbs31_enable <= 1'b0;
      phy.cfg_rx_prbs31_enable <= 1'b0;
    end else begin
      state_q                  <= state_d;
      res_q                    <= res_d;
      busy                     <= is_busy(state_d);
      done                     <= (state_d == ST_DONE);
      pass                     <= res_d.pass;
      fail_code                <= res_d.code;
      err_total                <= res_d.err;
      link_up                  <= (state_d == ST_DONE) && res_d.pass && phy.rx_status;
      phy.phy_reset_req        <= (state_d == ST_PHY_RST);
      phy.cfg_tx_prbs31_enable <= (state_d == ST_PRBS_SETTLE) || (state_d == ST_PRBS_TEST);
      phy.cfg_rx_prbs31_enable <= (state_d == ST_PRBS_SETTLE) || (state_d == ST_PRBS_TEST);
    end
  end

  // Next-state logic; timeouts beat success, abort beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_PHY_RST;
      ST_PHY_RST:       if (tc_hit_c) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (tc_hit_c)               state_d = ST_DONE;
        else if (phy.rx_block_lock) state_d = ST_PRBS_SETTLE;
      end
      ST_PRBS_SETTLE:   if (tc_hit_c) state_d = ST_PRBS_TEST;
      ST_PRBS_TEST: begin
        if (!phy.rx_block_lock) state_d = ST_DONE;
        else if (tc_hit_c)      state_d = ST_NORM_SETTLE;
      end
      ST_NORM_SETTLE:   if (tc_hit_c) state_d = ST_WAIT_STATUS;
      ST_WAIT_STATUS:   if (tc_hit_c || phy.rx_status) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    if (abort && is_busy(state_q)) state_d = ST_DONE;
  end

  // Result bookkeeping: clear on accepted start, accumulate in window, grade on DONE entry.
  always_comb begin
    res_d = res_q;
    if ((state_d == ST_PHY_RST) && !is_busy(state_q)) begin
      res_d = '0;
    end
    if (state_q == ST_PRBS_TEST) begin
      res_d.err = sat_add(res_q.err, phy.rx_error_count);
    end
    if ((state_d == ST_DONE) && is_busy(state_q)) begin
      if (abort) begin
        res_d.code = FAIL_ABORTED;
      end else begin
        case (state_q)
          ST_WAIT_LOCK: res_d.code = FAIL_LOCK_TIMEOUT;
          ST_PRBS_TEST: res_d.code = FAIL_LOCK_LOST;
          ST_WAIT_STATUS: begin
            if (tc_hit_c)                            res_d.code = FAIL_STATUS_TIMEOUT;
            else if (res_q.err > ERR_W'(ERR_THRESHOLD)) res_d.code = FAIL_ERRORS;
            else begin
              res_d.code = FAIL_NONE;
              res_d.pass = 1'b1;
            end
          end
          default: res_d.code = res_q.code;
        endcase
      end
    end
  end

endmodule
